snoop_issuer_multi: RTL and testbench
=====================================

Name: snoop_issuer_multi

Overview:
Parametrised successor of the single-line MSI issuer. Holds coherence state and tag for LINES direct-mapped cache lines. Accepts CPU requests over a valid/ready handshake and resolves hit/miss internally by tag compare. Arbitrates for the snooping bus with req/grant and applies incoming snoops to its own lines. An optional MESI mode adds the Exclusive state and silent E->M upgrade.

Parameters:
LINES, 4, number of cache lines (power of 2, >=2); IDX_W = log2(LINES)
TAG_W, 8, tag width
MESI, 0, 1 enables Exclusive state; 0 gives pure MSI

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; clears all state
cpu_valid  in  1  CPU request valid
cpu_ready  out  1  block can accept a request
cpu_write  in  1  1=write, 0=read
cpu_index  in  IDX_W  line index
cpu_tag  in  TAG_W  request tag
cpu_done  out  1  one-cycle pulse: request completed
bus_req  out  1  bus request to arbiter
bus_grant  in  1  arbiter grant (one-cycle pulse)
bus_valid  out  1  message on bus this cycle
message  out  2  00 write_miss, 01 read_miss, 10 invalidate, 11 NA
bus_index  out  IDX_W  index of bus transaction
bus_tag  out  TAG_W  tag of bus transaction
writeBack  out  1  victim line M: write back, same cycle as bus_valid
bus_shared  in  1  sampled with bus_valid; another cache holds the line (MESI only)
snoop_valid  in  1  foreign bus transaction
snoop_message  in  2  foreign message, same encoding
snoop_index  in  IDX_W  foreign index
snoop_tag  in  TAG_W  foreign tag
snoop_flush  out  1  registered, one cycle after snoop hit on M line: supply data

Behaviour:
- Line state encoding: I=00, S=01, M=10, E=11 (E unreachable when MESI=0). Hit = tag match and state != I.
- Reset: all lines I, tags 0, FSM IDLE. cpu_ready=1; cpu_done, bus_req, bus_valid, writeBack, snoop_flush=0; message=NA; bus_index/bus_tag=0. Reset mid-transaction aborts it with no cpu_done.
- FSM states: IDLE, DECIDE, WAIT_GNT, DONE.
- IDLE: cpu_ready=1. Handshake on cpu_valid&&cpu_ready latches write/index/tag, then go to DECIDE. cpu_ready=0 in all other states.
- DECIDE, hit needing no bus (read hit S/E/M, write hit M, write hit E when MESI=1 with E->M silently): update state, go to DONE. Otherwise assert bus_req, go to WAIT_GNT.
- WAIT_GNT: bus_req held high until bus_grant. Grant cycle evaluates the line state at that cycle (snoops may have changed it) and drives bus_valid=1 with:
  - read miss: message=01, writeBack=(old state M and tag differs). New state S, or E if MESI and !bus_shared. Tag updated.
  - write miss: message=00, writeBack=(old M and tag differs). New state M, tag updated.
  - write hit S: message=10, new state M.
  - If the line became a hit needing no bus: bus_valid=0 and bus_req dropped; complete as a hit.
- Bus outputs are registered, one cycle after the grant. bus_req drops the same cycle as bus_valid. Then go to DONE.
- DONE: cpu_done=1 for one cycle, then go to IDLE. Minimum latency from handshake: hit, cpu_done 2 cycles later; miss, cpu_done 2 cycles after grant.
- Snoop, only on a line hit (tag match, state != I), applied every cycle in any FSM state:
  - 01 read_miss: M or E -> S.
  - 00 write_miss or 10 invalidate: any state -> I.
  - snoop_flush=1 next cycle if old state was M.
  - Snoop on a miss: no effect.
- Same-cycle snoop and own update on the same line: snoop applied first, own update wins.
- writeBack on a hit-tag M line is never asserted (no eviction).

Test Plan:
- Read to empty line idx 2 tag 0x15 -> bus_req; grant -> bus_valid, message=01, writeBack=0. MESI=0: state S, cpu_done. MESI=1 with bus_shared=0: state E.
- Write hit on S line -> message=10, state M. Second write same line -> no bus_req, cpu_done 2 cycles after handshake.
- Line idx 1 M tag 0x03; read tag 0x07 idx 1 -> message=01, writeBack=1, bus_tag=0x07, state S.
- MESI=1: E line write hit -> no bus activity, state M. Snoop read_miss same tag -> state S, snoop_flush=1 next cycle.
- Waiting for grant on write hit S; snoop invalidate same line before grant -> at grant message=00 (write miss), not 10.
- Reset asserted in WAIT_GNT -> next cycle bus_req=0, cpu_ready=1, all lines I, no cpu_done.

Source files
------------

// File: rtl/snoop_issuer_multi.sv
// snoop_issuer_multi: MSI/MESI coherence issuer for LINES direct-mapped cache lines.
// Accepts one CPU request at a time, resolves hit/miss by tag compare, arbitrates for the
// snooping bus with req/grant and applies foreign snoops to its own lines every cycle.
//
// Ports:
//   clock, reset                      posedge clock, synchronous active-high reset
//   cpu_valid/cpu_ready               CPU request handshake
//   cpu_write, cpu_index, cpu_tag     request attributes, latched on handshake
//   cpu_done                          one-cycle completion pulse
//   bus_req/bus_grant                 bus arbitration (grant is a one-cycle pulse)
//   bus_valid, message, bus_index,
//   bus_tag, writeBack                registered bus transaction, one cycle after grant
//   bus_shared                        sampled with bus_valid (MESI read miss: S vs E)
//   snoop_valid, snoop_message,
//   snoop_index, snoop_tag            foreign bus transaction
//   snoop_flush                       one cycle after a snoop hit on an M line
module snoop_issuer_multi #(
  parameter int unsigned LINES = 4,
  parameter int unsigned TAG_W = 8,
  parameter bit          MESI  = 1'b0,
  localparam int unsigned IDX_W = $clog2(LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic             cpu_write,
  input  logic [IDX_W-1:0] cpu_index,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             cpu_done,
  output logic             bus_req,
  input  logic             bus_grant,
  output logic             bus_valid,
  output logic [1:0]       message,
  output logic [IDX_W-1:0] bus_index,
  output logic [TAG_W-1:0] bus_tag,
  output logic             writeBack,
  input  logic             bus_shared,
  input  logic             snoop_valid,
  input  logic [1:0]       snoop_message,
  input  logic [IDX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0] snoop_tag,
  output logic             snoop_flush
);

  typedef enum logic [1:0] {StIdle, StDecide, StWaitGnt, StDone} fsm_e;

  localparam logic [1:0] LsI = 2'b00;
  localparam logic [1:0] LsS = 2'b01;
  localparam logic [1:0] LsM = 2'b10;
  localparam logic [1:0] LsE = 2'b11;

  localparam logic [1:0] MsgWriteMiss  = 2'b00;
  localparam logic [1:0] MsgReadMiss   = 2'b01;
  localparam logic [1:0] MsgInvalidate = 2'b10;
  localparam logic [1:0] MsgNa         = 2'b11;

  fsm_e             fsm;
  logic             req_write;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       line_state [LINES];
  logic [TAG_W-1:0] line_tag   [LINES];
  // Read miss in MESI mode: final S/E choice waits for bus_shared in the bus_valid cycle.
  logic             e_pending;

  logic [1:0] cur_state;
  logic       cur_hit;
  logic       cur_silent;
  logic [1:0] snp_state;
  logic       snp_hit;
  logic [1:0] snp_next;

  always_comb begin
    cur_state  = line_state[req_index];
    cur_hit    = (line_tag[req_index] == req_tag) && (cur_state != LsI);
    // Hit that completes without a bus transaction (E->M is silent in MESI mode).
    cur_silent = cur_hit && (!req_write || (cur_state == LsM) ||
                             (MESI && (cur_state == LsE)));

    snp_state = line_state[snoop_index];
    snp_hit   = snoop_valid && (line_tag[snoop_index] == snoop_tag) && (snp_state != LsI);
    snp_next  = snp_state;
    case (snoop_message)
      MsgReadMiss: begin
        if ((snp_state == LsM) || (snp_state == LsE)) snp_next = LsS;
      end
      MsgWriteMiss, MsgInvalidate: snp_next = LsI;
      default: snp_next = snp_state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm         <= StIdle;
      req_write   <= 1'b0;
      req_index   <= '0;
      req_tag     <= '0;
      e_pending   <= 1'b0;
      cpu_ready   <= 1'b1;
      cpu_done    <= 1'b0;
      bus_req     <= 1'b0;
      bus_valid   <= 1'b0;
      message     <= MsgNa;
      bus_index   <= '0;
      bus_tag     <= '0;
      writeBack   <= 1'b0;
      snoop_flush <= 1'b0;
      for (int unsigned i = 0; i < LINES; i++) begin
        line_state[i] <= LsI;
        line_tag[i]   <= '0;
      end
    end else begin
      cpu_done    <= 1'b0;
      snoop_flush <= snp_hit && (snp_state == LsM);

      // Snoop first; any own-line write below is a later NBA and therefore wins.
      if (snp_hit) line_state[snoop_index] <= snp_next;

      unique case (fsm)
        StIdle: begin
          if (cpu_valid) begin
            req_write <= cpu_write;
            req_index <= cpu_index;
            req_tag   <= cpu_tag;
            cpu_ready <= 1'b0;
            fsm       <= StDecide;
          end
        end

        StDecide: begin
          if (cur_silent) begin
            if (req_write && (cur_state == LsE)) line_state[req_index] <= LsM;
            cpu_done <= 1'b1;
            fsm      <= StDone;
          end else begin
            bus_req <= 1'b1;
            fsm     <= StWaitGnt;
          end
        end

        StWaitGnt: begin
          if (bus_valid) begin
            // Bus message cycle: retire it and finish the request.
            bus_valid <= 1'b0;
            message   <= MsgNa;
            writeBack <= 1'b0;
            if (e_pending && !bus_shared) line_state[req_index] <= LsE;
            e_pending <= 1'b0;
            cpu_done  <= 1'b1;
            fsm       <= StDone;
          end else if (bus_grant) begin
            bus_req <= 1'b0;
            // Re-evaluate: snoops while waiting may have changed the line.
            if (cur_silent) begin
              if (req_write && (cur_state == LsE)) line_state[req_index] <= LsM;
              cpu_done <= 1'b1;
              fsm      <= StDone;
            end else begin
              bus_valid <= 1'b1;
              bus_index <= req_index;
              bus_tag   <= req_tag;
              if (cur_hit) begin
                // Only a write hit on S reaches here.
                message               <= MsgInvalidate;
                writeBack             <= 1'b0;
                line_state[req_index] <= LsM;
              end else begin
                message               <= req_write ? MsgWriteMiss : MsgReadMiss;
                // A non-hit M line necessarily holds a different tag: evict it.
                writeBack             <= (cur_state == LsM);
                line_tag[req_index]   <= req_tag;
                line_state[req_index] <= req_write ? LsM : LsS;
                e_pending             <= MESI && !req_write;
              end
            end
          end
        end

        StDone: begin
          cpu_ready <= 1'b1;
          fsm       <= StIdle;
        end

        default: fsm <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_issuer_multi.sv
// Bench for snoop_issuer_multi: one MSI and one MESI instance, exercised one at a time
// (sel) and compared against a transaction-level line-state model.
module tb_snoop_issuer_multi;

  logic clock;
  logic reset;
  logic cpu_valid, cpu_write, bus_grant, bus_shared, snoop_valid;
  logic [1:0] cpu_index, snoop_index, snoop_message;
  logic [7:0] cpu_tag, snoop_tag;
  bit sel;

  logic       cpu_ready_w [2];
  logic       cpu_done_w  [2];
  logic       bus_req_w   [2];
  logic       bus_valid_w [2];
  logic [1:0] message_w   [2];
  logic [1:0] bus_index_w [2];
  logic [7:0] bus_tag_w   [2];
  logic       wb_w        [2];
  logic       flush_w     [2];

  logic [1:0] cpu_valid_g, bus_grant_g, snoop_valid_g;
  assign cpu_valid_g   = {cpu_valid && sel, cpu_valid && !sel};
  assign bus_grant_g   = {bus_grant && sel, bus_grant && !sel};
  assign snoop_valid_g = {snoop_valid && sel, snoop_valid && !sel};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    snoop_issuer_multi #(.LINES(4), .TAG_W(8), .MESI(g == 1)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .cpu_valid    (cpu_valid_g[g]),
      .cpu_ready    (cpu_ready_w[g]),
      .cpu_write    (cpu_write),
      .cpu_index    (cpu_index),
      .cpu_tag      (cpu_tag),
      .cpu_done     (cpu_done_w[g]),
      .bus_req      (bus_req_w[g]),
      .bus_grant    (bus_grant_g[g]),
      .bus_valid    (bus_valid_w[g]),
      .message      (message_w[g]),
      .bus_index    (bus_index_w[g]),
      .bus_tag      (bus_tag_w[g]),
      .writeBack    (wb_w[g]),
      .bus_shared   (bus_shared),
      .snoop_valid  (snoop_valid_g[g]),
      .snoop_message(snoop_message),
      .snoop_index  (snoop_index),
      .snoop_tag    (snoop_tag),
      .snoop_flush  (flush_w[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per DUT, per line, state (0=I 1=S 2=M 3=E) and tag.
  int m_st [2][4];
  int m_tg [2][4];
  int tag_pool [3] = '{32'h15, 32'h03, 32'h07};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (mesi=%0d): got=%0h exp=%0h", tag, sel, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        m_st[d][i] = 0;
        m_tg[d][i] = 0;
      end
  endtask

  task automatic apply_snoop(input int msg, input int idx, input int tag, output bit flush);
    int st;
    st = m_st[sel][idx];
    flush = 1'b0;
    if (m_tg[sel][idx] == tag && st != 0) begin
      flush = (st == 2);
      if (msg == 1 && (st == 2 || st == 3)) m_st[sel][idx] = 1;
      else if (msg == 0 || msg == 2) m_st[sel][idx] = 0;
    end
  endtask

  // One cycle carrying a foreign snoop; checks the flush response.
  task automatic snoop_once(input int msg, input int idx, input int tag);
    bit flush;
    snoop_valid   = 1'b1;
    snoop_message = msg[1:0];
    snoop_index   = idx[1:0];
    snoop_tag     = tag[7:0];
    step();
    snoop_valid = 1'b0;
    apply_snoop(msg, idx, tag, flush);
    check_eq("snoop_flush", 32'(flush_w[sel]), 32'(flush));
  endtask

  task automatic rand_snoop(input int near_idx);
    int idx, tag;
    idx = ($urandom_range(1, 0) == 1) ? near_idx : int'($urandom_range(3, 0));
    tag = ($urandom_range(1, 0) == 1) ? m_tg[sel][idx] : tag_pool[$urandom_range(2, 0)];
    snoop_once(int'($urandom_range(3, 0)), idx, tag);
  endtask

  task automatic do_req(input bit wr, input int idx, input int tag, input int gdelay,
                        input bit shared, input bit rnd_snoop, input bit force_inv);
    int st;
    bit hit, nobus, mesi;
    int exp_msg;
    bit exp_wb;
    mesi = sel;
    check_eq("cpu_ready_idle", 32'(cpu_ready_w[sel]), 1);
    cpu_valid = 1'b1;
    cpu_write = wr;
    cpu_index = idx[1:0];
    cpu_tag   = tag[7:0];
    step();
    cpu_valid = 1'b0;
    check_eq("cpu_ready_busy", 32'(cpu_ready_w[sel]), 0);
    st    = m_st[sel][idx];
    hit   = (m_tg[sel][idx] == tag) && (st != 0);
    nobus = hit && (!wr || st == 2 || st == 3);
    step();
    if (nobus) begin
      if (wr) m_st[sel][idx] = 2;
      check_eq("hit_done", 32'(cpu_done_w[sel]), 1);
      check_eq("hit_no_req", 32'(bus_req_w[sel]), 0);
      check_eq("hit_no_valid", 32'(bus_valid_w[sel]), 0);
    end else begin
      check_eq("miss_req", 32'(bus_req_w[sel]), 1);
      check_eq("miss_not_done", 32'(cpu_done_w[sel]), 0);
      for (int i = 0; i < gdelay; i++) begin
        if (force_inv && i == 0) snoop_once(2, idx, m_tg[sel][idx]);
        else if (rnd_snoop && $urandom_range(1, 0) == 1) rand_snoop(idx);
        else begin
          step();
          check_eq("snoop_flush_quiet", 32'(flush_w[sel]), 0);
        end
        check_eq("req_held", 32'(bus_req_w[sel]), 1);
      end
      bus_grant = 1'b1;
      step();
      bus_grant = 1'b0;
      check_eq("req_dropped", 32'(bus_req_w[sel]), 0);
      st    = m_st[sel][idx];
      hit   = (m_tg[sel][idx] == tag) && (st != 0);
      nobus = hit && (!wr || st == 2 || st == 3);
      if (nobus) begin
        if (wr) m_st[sel][idx] = 2;
        check_eq("late_hit_no_valid", 32'(bus_valid_w[sel]), 0);
        check_eq("late_hit_done", 32'(cpu_done_w[sel]), 1);
      end else begin
        if (hit) begin
          exp_msg = 2;
          exp_wb  = 1'b0;
          m_st[sel][idx] = 2;
        end else begin
          exp_msg = wr ? 0 : 1;
          exp_wb  = (st == 2);
          m_tg[sel][idx] = tag;
          m_st[sel][idx] = wr ? 2 : ((mesi && !shared) ? 3 : 1);
        end
        check_eq("bus_valid", 32'(bus_valid_w[sel]), 1);
        check_eq("message", 32'(message_w[sel]), 32'(exp_msg));
        check_eq("writeBack", 32'(wb_w[sel]), 32'(exp_wb));
        check_eq("bus_index", 32'(bus_index_w[sel]), 32'(idx));
        check_eq("bus_tag", 32'(bus_tag_w[sel]), 32'(tag));
        check_eq("not_done_yet", 32'(cpu_done_w[sel]), 0);
        bus_shared = shared;
        step();
        bus_shared = 1'b0;
        check_eq("miss_done", 32'(cpu_done_w[sel]), 1);
        check_eq("bus_valid_off", 32'(bus_valid_w[sel]), 0);
      end
    end
    step();
    check_eq("done_pulse_end", 32'(cpu_done_w[sel]), 0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ready", 32'(cpu_ready_w[sel]), 1);
    check_eq("rst_done", 32'(cpu_done_w[sel]), 0);
    check_eq("rst_req", 32'(bus_req_w[sel]), 0);
    check_eq("rst_valid", 32'(bus_valid_w[sel]), 0);
    check_eq("rst_wb", 32'(wb_w[sel]), 0);
    check_eq("rst_flush", 32'(flush_w[sel]), 0);
    check_eq("rst_msg", 32'(message_w[sel]), 3);
    check_eq("rst_bidx", 32'(bus_index_w[sel]), 0);
    check_eq("rst_btag", 32'(bus_tag_w[sel]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu_valid = 1'b0; cpu_write = 1'b0; cpu_index = '0; cpu_tag = '0;
    bus_grant = 1'b0; bus_shared = 1'b0;
    snoop_valid = 1'b0; snoop_message = '0; snoop_index = '0; snoop_tag = '0;
    sel = 1'b0;
    model_clear();
    step();
    step();
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      check_reset_outputs();
    end

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      do_req(1'b0, 2, 'h15, 1, 1'b0, 1'b0, 1'b0); // read miss: S (MSI) / E (MESI)
      do_req(1'b1, 2, 'h15, 0, 1'b0, 1'b0, 1'b0); // MSI invalidate, MESI silent E->M
      do_req(1'b1, 2, 'h15, 0, 1'b0, 1'b0, 1'b0); // write hit M: no bus
      do_req(1'b1, 1, 'h03, 0, 1'b0, 1'b0, 1'b0); // write miss -> M
      do_req(1'b0, 1, 'h07, 2, 1'b1, 1'b0, 1'b0); // evicts M: writeBack=1, state S
      if (sel) begin
        do_req(1'b0, 3, 'h20, 0, 1'b0, 1'b0, 1'b0); // E
        do_req(1'b1, 3, 'h20, 0, 1'b0, 1'b0, 1'b0); // silent E->M
        snoop_once(1, 3, 'h20);                     // M->S with flush
        check_eq("flush_m_line", 32'(flush_w[sel]), 1);
      end
      // Write hit S, invalidated while waiting: becomes a write miss.
      do_req(1'b1, 1, 'h07, 2, 1'b0, 1'b0, 1'b1);
      check_eq("inv_to_write_miss", {30'd0, m_st[sel][1][1:0]}, 2);
      for (int n = 0; n < 40; n++) begin
        do_req(1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
               tag_pool[$urandom_range(2, 0)], int'($urandom_range(3, 0)),
               1'($urandom_range(1, 0)), 1'b1, 1'b0);
        for (int k = 0; k < int'($urandom_range(2, 0)); k++) rand_snoop(int'($urandom_range(3, 0)));
      end
    end

    // Reset while waiting for grant aborts with no cpu_done and clears all lines.
    sel = 1'b0;
    do_req(1'b0, 2, 'h15, 0, 1'b0, 1'b0, 1'b0);
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_index = 2'd0; cpu_tag = 8'h5a;
    step();
    cpu_valid = 1'b0;
    step();
    check_eq("pre_reset_req", 32'(bus_req_w[sel]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    check_eq("abort_req", 32'(bus_req_w[sel]), 0);
    check_eq("abort_ready", 32'(cpu_ready_w[sel]), 1);
    check_eq("abort_done", 32'(cpu_done_w[sel]), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("abort_no_done", 32'(cpu_done_w[sel]), 0);
    end
    do_req(1'b0, 2, 'h15, 1, 1'b0, 1'b0, 1'b0); // was valid before reset: must miss

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
